halt_detector: RTL
==================

# halt_detector

Synthesizable, parametrised infinite-loop / halt detector that watches the committed-PC stream from writeback. It flags a halt once the same loop body of period 1..HIST_DEPTH has repeated REPEAT_THRESH times, then drains for DRAIN_CYCLES so in-flight stores can complete. It sits beside the CPU core and drives the RVFI halt signal and the testbench stop logic. It replaces the fixed single-pattern "pc-8 plus 3-cycle delay" check with arbitrary loop periods, a repeat threshold, a clear input and visible status outputs.

## Interface
- XLEN, 32, PC width
- HIST_DEPTH, 4, committed PCs kept in history; this is the maximum detectable loop period (≥1)
- REPEAT_THRESH, 2, consecutive matching commits needed to declare a loop (≥1)
- DRAIN_CYCLES, 3, cycles between detection and halt (≥0)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- clear  in  1  synchronous re-arm; same effect as rst on this block only
- halt  out  1  sticky halt flag
- armed  out  1  high while in DRAIN
- loop_pc  out  XLEN  commit_pc of the commit that reached threshold
- loop_period  out  $clog2(HIST_DEPTH+1)  locked period; 0 when none

## Operation
- History: hist[0..HIST_DEPTH-1], with hist[0] the most recent previous commit. Each entry has a valid bit.
  - Every commit_valid shifts commit_pc into hist[0] after comparison, in every state except HALTED.
- Match on a commit: P = smallest k in 1..HIST_DEPTH with hist[k-1] valid and equal to commit_pc; none → no match.
- States (halt_state_t): IDLE, TRACK, DRAIN, HALTED.
  - IDLE, commit with match P: lock period=P, cnt=1, then apply the threshold check. No match → stay in IDLE.
  - TRACK, commit with commit_pc == hist[period-1] (entry valid): cnt+1, saturating at REPEAT_THRESH.
  - TRACK, commit that does not match: re-evaluate exactly as IDLE. A new match relocks P with cnt=1; otherwise go to IDLE with period=0 and cnt=0.
  - Threshold check, applied whenever cnt becomes ≥ REPEAT_THRESH: capture loop_pc=commit_pc.
    - DRAIN_CYCLES==0 → HALTED.
    - Otherwise → DRAIN with dcnt=DRAIN_CYCLES.
  - DRAIN: decrement dcnt every cycle, independent of commits. dcnt==1 → HALTED. Commits are still shifted into history, but mismatches are ignored (no abort).
  - HALTED: sticky until rst or clear. Commits are ignored and history is frozen.
- Priority: rst > clear > commit.
- rst/clear effect: state=IDLE, all history valid bits cleared, cnt=0, dcnt=0, period=0, loop_pc=0.
- Cycles with commit_valid=0 do not change history, cnt or the TRACK/IDLE state.
- cnt width is $clog2(REPEAT_THRESH+1); dcnt width is $clog2(DRAIN_CYCLES+1), minimum 1.

## Timing
- Reset values: halt=0, armed=0, loop_pc=0, loop_period=0.
- All outputs are registered: halt = (state==HALTED), armed = (state==DRAIN).
- For a threshold commit sampled at edge t, halt is first high in cycle t+1+DRAIN_CYCLES.
  - armed is high for exactly DRAIN_CYCLES cycles, starting at t+1.
- loop_period updates on the edge of the commit that locks it. loop_pc updates on the threshold edge.
- A clear asserted in the same cycle as a threshold commit wins: the block ends in IDLE with everything zero.
- A period greater than HIST_DEPTH is never detected.

## Structure
- Add halt_state_t (IDLE, TRACK, DRAIN, HALTED) to the shared rv32i_types package.
- Sub-module pc_history_buf, parametrised by XLEN and HIST_DEPTH. It contains:
  - the valid-tagged shift register;
  - the priority match encoder, outputting match_valid and match_period;
  - an indexed read port hist_at(period) used for the TRACK compare.
- The FSM, counters and output registers live in halt_detector.

## Test plan
- Self-loop, defaults: commits 0x60, 0x64, 0x64, 0x64 on consecutive cycles.
  - The 3rd commit locks period=1 with cnt=1; the 4th reaches cnt=2.
  - armed is high for 3 cycles, then halt=1 from t+4; loop_pc=0x64, loop_period=1.
- Period-3 loop: 0x100, 0x104, 0x108 repeated, one commit every other cycle.
  - period locks at 3 on the second 0x100; halt asserts after the second 0x104 plus 3 cycles; loop_pc=0x104.
- Loop exit: 0x200, 0x204, 0x200 (TRACK, period=2), then 0x300 → back to IDLE with loop_period=0 and no halt.
- Period beyond depth: with HIST_DEPTH=4, repeat a 5-PC loop 10 times → halt stays 0 and loop_period stays 0.
- Clear and reset: assert clear while armed=1 → IDLE, history empty, and a fresh self-loop needs 3 commits again. Repeat with rst asserted in HALTED → halt=0 the next cycle.
- Parameter corners: DRAIN_CYCLES=0 with REPEAT_THRESH=1 on commits 0x40, 0x40 → halt=1 the cycle right after the second commit, and armed never asserts.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the rv32i core slice.
// Holds the halt detector FSM encoding and a small width helper.
package rv32i_types;

  // Halt detector states: IDLE (no loop seen), TRACK (period locked, counting
  // repeats), DRAIN (loop confirmed, letting in-flight stores finish),
  // HALTED (sticky until rst/clear).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } halt_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int width_min1(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/halt_detector_pc_history_buf.sv
// pc_history_buf: valid-tagged shift register of previously committed PCs.
//   clk          clock
//   flush        clear every valid bit (takes priority over shift_en)
//   shift_en     push pc into entry 0, older entries move down by one
//   pc           PC of the commit being compared (and shifted)
//   match_valid  some valid entry equals pc
//   match_period smallest k (1..HIST_DEPTH) with entry k-1 valid and == pc
//   rd_period    indexed read port, selects entry rd_period-1
//   rd_valid     valid bit of the selected entry (0 when rd_period is 0)
//   rd_pc        PC stored in the selected entry
// Entry 0 is always the most recent previous commit; matching uses the
// contents before this cycle's shift.
module pc_history_buf #(
  parameter int XLEN       = 32,
  parameter int HIST_DEPTH = 4,
  localparam int PW        = $clog2(HIST_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            flush,
  input  logic            shift_en,
  input  logic [XLEN-1:0] pc,
  output logic            match_valid,
  output logic [PW-1:0]   match_period,
  input  logic [PW-1:0]   rd_period,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_pc
);

  logic [XLEN-1:0] hist_pc  [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld;

  always_ff @(posedge clk) begin
    if (flush) begin
      hist_vld <= '0;
    end else if (shift_en) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_pc[i]  <= hist_pc[i-1];
        hist_vld[i] <= hist_vld[i-1];
      end
      hist_pc[0]  <= pc;
      hist_vld[0] <= 1'b1;
    end
  end

  // Walk from the deepest entry toward entry 0 so the last hit written is
  // the smallest period.
  always_comb begin
    match_valid  = 1'b0;
    match_period = '0;
    for (int k = HIST_DEPTH; k >= 1; k--) begin
      if (hist_vld[k-1] && (hist_pc[k-1] == pc)) begin
        match_valid  = 1'b1;
        match_period = PW'(k);
      end
    end
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_pc    = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (rd_period == PW'(i + 1)) begin
        rd_valid = hist_vld[i];
        rd_pc    = hist_pc[i];
      end
    end
  end

endmodule

// File: rtl/halt_detector.sv
// halt_detector: watches the committed-PC stream and raises a sticky halt
// once a loop of period 1..HIST_DEPTH has repeated REPEAT_THRESH times,
// after a DRAIN_CYCLES grace period.
//   clk          clock
//   rst          synchronous active-high reset
//   commit_valid one instruction retires this cycle
//   commit_pc    PC of the retiring instruction
//   clear        synchronous re-arm, same effect as rst on this block
//   halt         sticky halt flag (state == HALTED)
//   armed        high while draining (state == DRAIN)
//   loop_pc      commit_pc of the commit that reached the threshold
//   loop_period  locked loop period, 0 when none
//   state_dbg    current FSM state
// Handshake: commit_valid is a one-cycle qualifier with no back-pressure;
// every cycle it is high the commit is consumed. All outputs come straight
// from registers.
module halt_detector
  import rv32i_types::*;
#(
  parameter int XLEN          = 32,
  parameter int HIST_DEPTH    = 4,
  parameter int REPEAT_THRESH = 2,
  parameter int DRAIN_CYCLES  = 3,
  localparam int PW           = $clog2(HIST_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            clear,
  output logic            halt,
  output logic            armed,
  output logic [XLEN-1:0] loop_pc,
  output logic [PW-1:0]   loop_period,
  output halt_state_t     state_dbg
);

  localparam int CW = width_min1(REPEAT_THRESH);
  localparam int DW = width_min1(DRAIN_CYCLES);

  halt_state_t     state_q, state_d;
  logic [PW-1:0]   period_q, period_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [XLEN-1:0] loop_pc_q, loop_pc_d;

  logic            match_valid;
  logic [PW-1:0]   match_period;
  logic            rd_valid;
  logic [XLEN-1:0] rd_pc;
  logic            shift_en;
  logic            thresh_hit;

  // History is frozen once halted; otherwise every commit is recorded.
  assign shift_en = commit_valid && (state_q != HALTED);

  pc_history_buf #(
    .XLEN      (XLEN),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk         (clk),
    .flush       (rst || clear),
    .shift_en    (shift_en),
    .pc          (commit_pc),
    .match_valid (match_valid),
    .match_period(match_period),
    .rd_period   (period_q),
    .rd_valid    (rd_valid),
    .rd_pc       (rd_pc)
  );

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    loop_pc_d  = loop_pc_q;
    thresh_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (commit_valid && match_valid) begin
          state_d  = TRACK;
          period_d = match_period;
          cnt_d    = CW'(1);
        end
      end
      TRACK: begin
        if (commit_valid) begin
          if (rd_valid && (rd_pc == commit_pc)) begin
            if (cnt_q < CW'(REPEAT_THRESH)) cnt_d = cnt_q + CW'(1);
          end else if (match_valid) begin
            // Loop shape changed: relock on the new period.
            period_d = match_period;
            cnt_d    = CW'(1);
          end else begin
            state_d  = IDLE;
            period_d = '0;
            cnt_d    = '0;
          end
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q - DW'(1);
        if (dcnt_q <= DW'(1)) state_d = HALTED;
      end
      default: ;
    endcase

    // Threshold check covers both a fresh lock (REPEAT_THRESH == 1) and a
    // repeat in TRACK. cnt_d is 0 whenever no loop is locked.
    if (commit_valid && ((state_q == IDLE) || (state_q == TRACK)) &&
        (cnt_d >= CW'(REPEAT_THRESH))) begin
      thresh_hit = 1'b1;
    end

    if (thresh_hit) begin
      loop_pc_d = commit_pc;
      dcnt_d    = DW'(DRAIN_CYCLES);
      state_d   = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= IDLE;
      period_q  <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      loop_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      loop_pc_q <= loop_pc_d;
    end
  end

  assign halt        = (state_q == HALTED);
  assign armed       = (state_q == DRAIN);
  assign loop_pc     = loop_pc_q;
  assign loop_period = period_q;
  assign state_dbg   = state_q;

endmodule
